// File: rtl/uart_rx_deserializer.sv
// UART receive engine: 16x oversampled, 2-of-3 vote at mid-bit, optional parity,
// LSB-first deserialization into a one-byte holding register with valid/ready handoff.
//   state     | meaning
//   ST_IDLE   | waiting for a falling line (and for the line to return high after a break)
//   ST_START  | confirming the start bit, false start returns to idle
//   ST_DATA   | shifting DATA_BITS data bits, LSB first
//   ST_PARITY | sampling the parity bit (odd/even modes only)
//   ST_STOP   | sampling the stop bit, back to idle at mid-bit
module uart_rx_deserializer #(
   parameter int DATA_BITS = 8,
   parameter int OVS       = 16,
   parameter int DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RxPort_i,
   input  logic                 RxEnable_i,
   input  logic [DIV_W-1:0]     BaudDiv_i,
   input  logic [1:0]           ParityMode_i,
   output logic [DATA_BITS-1:0] RxData_o,
   output logic                 RxValid_o,
   input  logic                 RxReady_i,
   output logic                 ParityErr_o,
   output logic                 FrameErr_o,
   output logic                 Overrun_o,
   input  logic                 ErrClr_i,
   output logic                 RxBusy_o
);

   localparam int SW  = $clog2(OVS);
   localparam int BCW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   state_t                 state_q, state_d;
   logic                   rx_s1_q, rx_s2_q, rx_line;
   logic [DIV_W-1:0]       tick_cnt_q, tick_cnt_d, div_m1;
   logic                   tick;
   logic [SW-1:0]          s_q, s_d;
   logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                   v7_q, v8_q, vote;
   logic [DATA_BITS-1:0]   shift_q, data_q;
   logic                   perr_q, ferr_q, done_q, wait_high_q;
   logic                   valid_q, perr_hold_q, ferr_hold_q, ovr_q;
   logic                   start_det, samp7, samp8, decide, bit_end, last_bit, par_en, load;

   assign rx_line   = rx_s2_q;
   assign div_m1    = (BaudDiv_i == '0) ? '0 : BaudDiv_i - DIV_W'(1);
   assign tick      = (tick_cnt_q >= div_m1);
   assign par_en    = ^ParityMode_i;
   assign last_bit  = (bit_cnt_q == BCW'(DATA_BITS-1));
   assign vote      = (v7_q & v8_q) | (v7_q & rx_line) | (v8_q & rx_line);
   assign start_det = (state_q == ST_IDLE) & RxEnable_i & ~rx_line & ~wait_high_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         tick_cnt_q <= '0;
         s_q        <= '0;
         bit_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rx_s1_q    <= RxPort_i;
         rx_s2_q    <= rx_s1_q;
         tick_cnt_q <= tick_cnt_d;
         s_q        <= s_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!RxEnable_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (start_det) state_d = ST_START;
            ST_START:  if (decide && vote) state_d = ST_IDLE;
                       else if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && last_bit) state_d = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (decide) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      RxBusy_o = (state_q != ST_IDLE);
      samp7    = RxBusy_o & tick & (s_q == SW'(7));
      samp8    = RxBusy_o & tick & (s_q == SW'(8));
      decide   = RxBusy_o & tick & (s_q == SW'(9));
      bit_end  = RxBusy_o & tick & (s_q == SW'(OVS-1));
   end

   always_comb begin
      tick_cnt_d = (start_det || tick) ? '0 : tick_cnt_q + DIV_W'(1);
      s_d        = s_q;
      if (state_q == ST_IDLE || state_d == ST_IDLE) s_d = '0;
      else if (tick)                                s_d = s_q + SW'(1);
      bit_cnt_d  = bit_cnt_q;
      if (state_q != ST_DATA) bit_cnt_d = '0;
      else if (bit_end)       bit_cnt_d = bit_cnt_q + BCW'(1);
   end

   // Frame-side registers stay put until the next frame reaches DATA, so the
   // delivery edge one cycle after the stop decision sees a stable byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v7_q        <= 1'b1;
         v8_q        <= 1'b1;
         shift_q     <= '0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         done_q      <= 1'b0;
         wait_high_q <= 1'b0;
      end else begin
         if (samp7) v7_q <= rx_line;
         if (samp8) v8_q <= rx_line;
         if (state_q == ST_DATA && decide) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
         if (state_q == ST_START && bit_end) perr_q <= 1'b0;
         if (state_q == ST_PARITY && decide)
            perr_q <= (^{shift_q, vote}) ^ (ParityMode_i == 2'b01);
         done_q <= (state_q == ST_STOP) & decide & RxEnable_i;
         if (state_q == ST_STOP && decide) ferr_q <= ~vote;
         if (state_q == ST_STOP && decide && !vote) wait_high_q <= 1'b1;
         else if (rx_line)                          wait_high_q <= 1'b0;
      end
   end

   assign load = done_q & (~valid_q | RxReady_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q      <= '0;
         valid_q     <= 1'b0;
         perr_hold_q <= 1'b0;
         ferr_hold_q <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         if (load) begin
            data_q      <= shift_q;
            perr_hold_q <= perr_q;
            ferr_hold_q <= ferr_q;
            valid_q     <= 1'b1;
         end else if (valid_q && RxReady_i) begin
            valid_q <= 1'b0;
         end
         if (done_q && !load) ovr_q <= 1'b1;
         else if (ErrClr_i)   ovr_q <= 1'b0;
      end
   end

   assign RxData_o    = data_q;
   assign RxValid_o   = valid_q;
   assign ParityErr_o = perr_hold_q;
   assign FrameErr_o  = ferr_hold_q;
   assign Overrun_o   = ovr_q;

endmodule
